multdiv_iter: RTL and testbench

- Iterative signed multiply/divide unit in the execute stage, alongside the 32-bit ALU (and32/or32/adder datapath).
- Takes the same operand pair the ALU receives. Produces a 32-bit result after a fixed multi-cycle latency.
- Flags overflow or divide-by-zero.
- The pipeline control stalls on it until data_resultRDY pulses.

---
 rtl/multdiv_iter.sv | 177 +++++++++++++++++
 tb/tb_multdiv_iter.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/multdiv_iter.sv
// Iterative signed multiply/divide unit: radix-2 Booth multiply and restoring
// magnitude divide, fixed WIDTH+1 cycle latency with a one-cycle ready pulse.
module multdiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]    CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MIN_W    = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONES_W   = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Unsigned magnitude; the most negative value maps to 2^(WIDTH-1) exactly.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        magnitude = v[WIDTH-1] ? (~v + ONE_W) : v;
    endfunction

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        negate = ~v + ONE_W;
    endfunction

    state_t             state_r;
    logic [CW-1:0]      cnt_r;
    logic               is_mul_r;
    logic [2*WIDTH:0]   prod_r;
    logic [WIDTH-1:0]   mcand_r;
    logic [WIDTH-1:0]   rem_r;
    logic [WIDTH-1:0]   quo_r;
    logic [WIDTH-1:0]   dvs_r;
    logic               neg_q_r;
    logic               div_zero_r;
    logic               div_ovf_r;

    logic               start_s;
    logic [WIDTH:0]     up_ext_s;
    logic [WIDTH:0]     m_ext_s;
    logic [WIDTH:0]     booth_sum_s;
    logic [2*WIDTH:0]   prod_next_s;
    logic [WIDTH:0]     rem_shift_s;
    logic               rem_ge_s;
    logic [WIDTH-1:0]   rem_diff_s;
    logic [WIDTH-1:0]   rem_next_s;
    logic [WIDTH-1:0]   quo_next_s;
    logic [WIDTH:0]     prod_hi_s;
    logic [WIDTH-1:0]   fin_result_s;
    logic               fin_exc_s;

    assign start_s = ctrl_MULT | ctrl_DIV;

    // One Booth step; the add is one bit wider so a -2^(WIDTH-1) multiplicand cannot wrap.
    always_comb begin
        up_ext_s    = {prod_r[2*WIDTH], prod_r[2*WIDTH:WIDTH+1]};
        m_ext_s     = {mcand_r[WIDTH-1], mcand_r};
        booth_sum_s = up_ext_s;
        case (prod_r[1:0])
            2'b01:   booth_sum_s = up_ext_s + m_ext_s;
            2'b10:   booth_sum_s = up_ext_s - m_ext_s;
            default: booth_sum_s = up_ext_s;
        endcase
        prod_next_s = {booth_sum_s, prod_r[WIDTH:1]};
    end

    // One restoring-division step on magnitudes.
    always_comb begin
        rem_shift_s = {rem_r, quo_r[WIDTH-1]};
        rem_ge_s    = (rem_shift_s >= {1'b0, dvs_r});
        rem_diff_s  = rem_shift_s[WIDTH-1:0] - dvs_r;
        if (rem_ge_s) begin
            rem_next_s = rem_diff_s;
            quo_next_s = {quo_r[WIDTH-2:0], 1'b1};
        end else begin
            rem_next_s = rem_shift_s[WIDTH-1:0];
            quo_next_s = {quo_r[WIDTH-2:0], 1'b0};
        end
    end

    // Final result and exception selection for the completing operation.
    always_comb begin
        prod_hi_s = prod_r[2*WIDTH:WIDTH];
        if (is_mul_r) begin
            fin_result_s = prod_r[WIDTH:1];
            fin_exc_s    = (prod_hi_s != {(WIDTH+1){1'b0}}) && (prod_hi_s != {(WIDTH+1){1'b1}});
        end else if (div_zero_r) begin
            fin_result_s = ZERO_W;
            fin_exc_s    = 1'b1;
        end else if (div_ovf_r) begin
            fin_result_s = MIN_W;
            fin_exc_s    = 1'b1;
        end else begin
            fin_result_s = neg_q_r ? negate(quo_r) : quo_r;
            fin_exc_s    = 1'b0;
        end
    end

    // Control FSM, iteration datapath registers and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r        <= IDLE;
            cnt_r          <= {CW{1'b0}};
            is_mul_r       <= 1'b0;
            prod_r         <= {(2*WIDTH+1){1'b0}};
            mcand_r        <= ZERO_W;
            rem_r          <= ZERO_W;
            quo_r          <= ZERO_W;
            dvs_r          <= ZERO_W;
            neg_q_r        <= 1'b0;
            div_zero_r     <= 1'b0;
            div_ovf_r      <= 1'b0;
            data_result    <= ZERO_W;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else if (start_s) begin
            // A start in any state restarts; multiply wins over divide.
            state_r        <= ctrl_MULT ? MUL : DIV;
            cnt_r          <= {CW{1'b0}};
            is_mul_r       <= ctrl_MULT;
            prod_r         <= {ZERO_W, data_operandB, 1'b0};
            mcand_r        <= data_operandA;
            rem_r          <= ZERO_W;
            quo_r          <= magnitude(data_operandA);
            dvs_r          <= magnitude(data_operandB);
            neg_q_r        <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            div_zero_r     <= (data_operandB == ZERO_W);
            div_ovf_r      <= (data_operandA == MIN_W) && (data_operandB == ONES_W);
            data_resultRDY <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    data_resultRDY <= 1'b0;
                end
                MUL: begin
                    prod_r         <= prod_next_s;
                    cnt_r          <= cnt_r + CNT_ONE;
                    state_r        <= (cnt_r == CNT_LAST) ? DONE : MUL;
                    data_resultRDY <= 1'b0;
                end
                DIV: begin
                    rem_r          <= rem_next_s;
                    quo_r          <= quo_next_s;
                    cnt_r          <= cnt_r + CNT_ONE;
                    state_r        <= (cnt_r == CNT_LAST) ? DONE : DIV;
                    data_resultRDY <= 1'b0;
                end
                DONE: begin
                    data_result    <= fin_result_s;
                    data_exception <= fin_exc_s;
                    data_resultRDY <= 1'b1;
                    state_r        <= IDLE;
                end
                default: begin
                    state_r        <= IDLE;
                    data_resultRDY <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv_iter.sv
// Directed self-checking bench for multdiv_iter: latency, results, exceptions,
// restart/priority, mid-operation reset and output hold.
module tb_multdiv_iter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] data_operandA = 32'd0;
    logic [31:0] data_operandB = 32'd0;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    int checks = 0;
    int errors = 0;

    multdiv_iter #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive a one-cycle start pulse; the rising edge in between is edge 0.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic m, input logic d);
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        @(negedge clock);
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
    endtask

    // Count edges from the start edge until RDY is seen, bounded at 40.
    task automatic wait_rdy(output int n);
        logic found;
        n = 1;
        @(posedge clock);
        #1;
        found = data_resultRDY;
        while (!found && n < 40) begin
            @(posedge clock);
            #1;
            n++;
            found = data_resultRDY;
        end
    endtask

    task automatic finish_op(input string tag, input logic [31:0] exp_res, input logic exp_exc);
        int n;
        wait_rdy(n);
        check({tag, "_latency"}, 32'(n), 32'd33);
        check({tag, "_result"}, data_result, exp_res);
        check({tag, "_exc"}, {31'd0, data_exception}, {31'd0, exp_exc});
        @(posedge clock);
        #1;
        check({tag, "_rdy_pulse"}, {31'd0, data_resultRDY}, 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic m, input logic d,
                          input logic [31:0] exp_res, input logic exp_exc);
        start_op(a, b, m, d);
        finish_op(tag, exp_res, exp_exc);
    endtask

    initial begin
        int seen;

        repeat (2) @(posedge clock);
        #1;
        check("reset_result", data_result, 32'd0);
        check("reset_exc", {31'd0, data_exception}, 32'd0);
        check("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        run_op("mul_7x6",     32'd7,          32'd6,          1'b1, 1'b0, 32'd42,         1'b0);
        run_op("mul_m3x5",    32'hFFFF_FFFD,  32'd5,          1'b1, 1'b0, 32'hFFFF_FFF1,  1'b0);
        run_op("mul_ovf",     32'h0001_0000,  32'h0001_0000,  1'b1, 1'b0, 32'h0000_0000,  1'b1);
        run_op("mul_min_m1",  32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 1'b0, 32'h8000_0000,  1'b1);

        run_op("div_100_7",   32'd100,        32'd7,          1'b0, 1'b1, 32'd14,         1'b0);
        run_op("div_m100_7",  32'hFFFF_FF9C,  32'd7,          1'b0, 1'b1, 32'hFFFF_FFF2,  1'b0);
        run_op("div_7_100",   32'd7,          32'd100,        1'b0, 1'b1, 32'd0,          1'b0);
        run_op("div_by_zero", 32'd12345,      32'd0,          1'b0, 1'b1, 32'd0,          1'b1);
        run_op("div_min_m1",  32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 1'b1, 32'h8000_0000,  1'b1);
        run_op("div_min_2",   32'h8000_0000,  32'd2,          1'b0, 1'b1, 32'hC000_0000,  1'b0);

        // Restart: divide aborted by a multiply ten cycles later.
        start_op(32'd50, 32'd5, 1'b0, 1'b1);
        seen = 0;
        repeat (9) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) seen++;
        end
        start_op(32'd3, 32'd4, 1'b1, 1'b0);
        check("restart_no_early_rdy", 32'(seen), 32'd0);
        finish_op("restart_mul", 32'd12, 1'b0);

        run_op("both_ctrl", 32'd9, 32'd3, 1'b1, 1'b1, 32'd27, 1'b0);

        // Reset at cycle 15 of a multiply: no RDY afterwards, outputs cleared.
        start_op(32'd2, 32'd2, 1'b1, 1'b0);
        repeat (13) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        seen = 0;
        repeat (45) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) seen++;
        end
        check("midreset_no_rdy", 32'(seen), 32'd0);
        check("midreset_result", data_result, 32'd0);
        check("midreset_exc", {31'd0, data_exception}, 32'd0);

        // Hold: outputs stable while operands toggle with no start.
        run_op("hold_setup", 32'hFFFF_FFF9, 32'd6, 1'b1, 1'b0, 32'hFFFF_FFD6, 1'b0);
        repeat (50) begin
            @(negedge clock);
            data_operandA = $urandom;
            data_operandB = $urandom;
            @(posedge clock);
            #1;
            check("hold_result", data_result, 32'hFFFF_FFD6);
            check("hold_flags", {30'd0, data_resultRDY, data_exception}, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
